// File: rtl/multdiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Build option: MULTDIV_DIV_EN compiles in the divide datapath.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] ITER_LAST = 6'd32;
    localparam logic [CNT_W-1:0] CNT_DONE  = 6'd33;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_iter_counter.sv
// One-shot iteration counter: start->1, 1..32 step, 33 (done) -> 0 idle.
// start_done jumps straight to the done count.
module multdiv_iter_counter
    import multdiv_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic start_done,
    output logic running,
    output logic done
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign running = (cnt_q != '0) && (cnt_q <= ITER_LAST);
    assign done    = (cnt_q == CNT_DONE);

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 6'd1;
        end else if (start_done) begin
            cnt_d = CNT_DONE;
        end else if (running) begin
            cnt_d = cnt_q + 6'd1;
        end else if (done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Build option: MULTDIV_DIV_EN compiles in the divide datapath.
module multdiv
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int AW = 2 * WIDTH + 1;

    logic             start;
    logic             load_one;
    logic             load_done;
    logic             running;
    logic             done;

    op_e              op_d, op_q;
    logic [WIDTH-1:0] opa_d, opa_q;
    logic [AW-1:0]    acc_d, acc_q;
    logic [WIDTH-1:0] res_d, res_q;
    logic             exc_d, exc_q;
    logic             rdy_d, rdy_q;

    logic [WIDTH-1:0] b_hi;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   b_m;
    logic [WIDTH:0]   b_sum;
    logic [AW-1:0]    booth_next;
    logic [AW-1:0]    mult_load;
    logic [WIDTH:0]   prod_hi;
    logic             mult_ovf;

    logic [AW-1:0]    div_load;
    logic [AW-1:0]    div_next;
    logic [WIDTH-1:0] div_res;
    logic             div_exc;

    assign start = ctrl_MULT | ctrl_DIV;

    multdiv_iter_counter u_cnt (
        .clock      (clock),
        .reset      (reset),
        .start      (load_one),
        .start_done (load_done),
        .running    (running),
        .done       (done)
    );

    // Sum is formed one bit wider so a -2^(W-1) multiplicand cannot overflow
    assign b_hi       = acc_q[AW-1:WIDTH+1];
    assign b_ext      = {b_hi[WIDTH-1], b_hi};
    assign b_m        = {opa_q[WIDTH-1], opa_q};
    assign booth_next = {b_sum, acc_q[WIDTH:1]};
    assign mult_load  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
    assign prod_hi    = acc_q[AW-1:WIDTH];
    assign mult_ovf   = !((&prod_hi) || !(|prod_hi));

    always_comb begin
        b_sum = b_ext;
        case (acc_q[1:0])
            2'b01:   b_sum = b_ext + b_m;
            2'b10:   b_sum = b_ext - b_m;
            default: b_sum = b_ext;
        endcase
    end

`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0] opb_d, opb_q;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH:0]   d_rem;
    logic [WIDTH:0]   d_shift;
    logic [WIDTH+1:0] d_diff;
    logic             d_neg;
    logic             q_neg;
    logic             div_zero;
    logic             div_ovf;

    assign load_one  = start;
    assign load_done = 1'b0;

    assign mag_a_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b    = opb_q[WIDTH-1] ? -opb_q : opb_q;
    assign div_load = {{(WIDTH+1){1'b0}}, mag_a_in};

    // Remainder sits in the top W+1 bits, quotient shifts in at the bottom
    assign d_rem    = acc_q[AW-1:WIDTH];
    assign quo      = acc_q[WIDTH-1:0];
    assign d_shift  = {d_rem[WIDTH-1:0], quo[WIDTH-1]};
    assign d_diff   = {1'b0, d_shift} - {2'b00, mag_b};
    assign d_neg    = d_diff[WIDTH+1];
    assign div_next = {d_neg ? d_shift : d_diff[WIDTH:0],
                       quo[WIDTH-2:0], ~d_neg};

    assign q_neg    = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
    assign quo_s    = q_neg ? -quo : quo;
    assign div_zero = (opb_q == '0);
    assign div_ovf  = (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&opb_q);

    always_comb begin
        div_res = quo_s;
        div_exc = 1'b0;
        if (div_zero) begin
            div_res = '0;
            div_exc = 1'b1;
        end else if (div_ovf) begin
            div_res = {1'b1, {(WIDTH-1){1'b0}}};
            div_exc = 1'b1;
        end
    end

    always_comb begin
        opb_d = opb_q;
        if (start) begin
            opb_d = data_operandB;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opb_q <= '0;
        end else begin
            opb_q <= opb_d;
        end
    end
`else
    assign load_one  = ctrl_MULT;
    assign load_done = ctrl_DIV & ~ctrl_MULT;
    assign div_load  = mult_load;
    assign div_next  = acc_q;
    assign div_res   = '0;
    assign div_exc   = 1'b1;
`endif

    always_comb begin
        op_d  = op_q;
        opa_d = opa_q;
        acc_d = acc_q;
        res_d = res_q;
        exc_d = exc_q;
        rdy_d = 1'b0;
        if (start) begin
            op_d  = ctrl_MULT ? OP_MULT : OP_DIV;
            opa_d = data_operandA;
            acc_d = ctrl_MULT ? mult_load : div_load;
        end else if (running) begin
            acc_d = (op_q == OP_MULT) ? booth_next : div_next;
        end else if (done) begin
            rdy_d = 1'b1;
            if (op_q == OP_MULT) begin
                res_d = acc_q[WIDTH:1];
                exc_d = mult_ovf;
            end else begin
                res_d = div_res;
                exc_d = div_exc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q  <= OP_MULT;
            opa_q <= '0;
            acc_q <= '0;
            res_q <= '0;
            exc_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            opa_q <= opa_d;
            acc_q <= acc_d;
            res_q <= res_d;
            exc_q <= exc_d;
            rdy_q <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv with an arithmetic reference model.
// Divide expectations follow MULTDIV_DIV_EN.
module tb_multdiv;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // model state
    int          m_left = 0;
    logic [31:0] m_pend_res = '0;
    logic        m_pend_exc = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_exc = 1'b0;
    logic        m_rdy = 1'b0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    function automatic logic [32:0] model_op(input bit m,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint      p;
        longint      lo_ext;
        logic [31:0] lo;
        logic [31:0] q;
        if (m) begin
            p      = longint'($signed(a)) * longint'($signed(b));
            lo     = p[31:0];
            lo_ext = longint'($signed(lo));
            return {p != lo_ext, lo};
        end
        if (!DIV_EN) return {1'b1, 32'h0};
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [32:0] r;
        if (!reset) begin
            m_left     <= 0;
            m_pend_res <= '0;
            m_pend_exc <= 1'b0;
            m_res      <= '0;
            m_exc      <= 1'b0;
            m_rdy      <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                r = model_op(ctrl_MULT, data_operandA, data_operandB);
                m_pend_res <= r[31:0];
                m_pend_exc <= r[32];
                m_left     <= (ctrl_MULT || DIV_EN) ? 33 : 1;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_rdy <= 1'b1;
                    m_res <= m_pend_res;
                    m_exc <= m_pend_exc;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            n_vec++;
            if (data_resultRDY !== m_rdy || data_result !== m_res ||
                data_exception !== m_exc) begin
                n_err++;
                $display("FAIL cycle t=%0t rdy/res/exc got %b/%h/%b want %b/%h/%b",
                         $time, data_resultRDY, data_result, data_exception,
                         m_rdy, m_res, m_exc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Called mid-cycle; the start is sampled on the next rising edge.
    task automatic run_op(input string name, input bit mul, input bit div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want_res, input bit want_exc,
                          input int want_lat);
        int lat;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #2;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        check({name, " latency"}, lat, want_lat);
        check({name, " result"}, data_result, want_res);
        check({name, " exception"}, {31'b0, data_exception}, {31'b0, want_exc});
    endtask

    initial begin
        int rdy_seen;
        #2 reset = 1'b0;
        check_en = 1'b1;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("reset result", data_result, 32'h0);
        check("reset exc", {31'b0, data_exception}, 32'h0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'h0);

        run_op("mul 7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33);
        run_op("mul 2^16sq", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 33);
        run_op("mul max", 1, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 0, 33);
        run_op("mul min*-1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33);
        run_op("mul min*min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 33);
        run_op("mul -1*-1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 33);

        if (DIV_EN) begin
            run_op("div -100/7", 0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 33);
            run_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'h0, 1, 33);
            run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33);
            run_op("div 7/-2", 0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 33);
        end else begin
            run_op("div off", 0, 1, 32'hFFFF_FF9C, 32'd7, 32'h0, 1, 1);
        end

        // abort a multiply with a divide started 10 edges later
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(posedge clock);
        #2 ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        if (DIV_EN)
            run_op("abort div", 0, 1, 32'd20, 32'd4, 32'd5, 0, 33);
        else
            run_op("abort div", 0, 1, 32'd20, 32'd4, 32'h0, 1, 1);

        // reset in the middle of a multiply
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd6;
        @(posedge clock);
        #2 ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst result", data_result, 32'h0);
        check("midrst exc", {31'b0, data_exception}, 32'h0);
        check("midrst rdy", {31'b0, data_resultRDY}, 32'h0);
        @(posedge clock);
        #2 reset = 1'b1;
        rdy_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("no rdy after reset", rdy_seen, 32'd0);
        run_op("mul 6x6", 1, 0, 32'd6, 32'd6, 32'd36, 0, 33);

        run_op("both starts", 1, 1, 32'd9, 32'd3, 32'd27, 0, 33);

        repeat (3) @(posedge clock);
        #1;
        check("idle result hold", data_result, 32'd27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
